// File: rtl/ahb_ctrl_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the round-robin master.
package ahb_ctrl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [3:0] HPROT_DATA = 4'b0011;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b10
  } state_e;

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter: searches upward from last_grant+1 (mod NUM_REQ) for the first active request.
module ahb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    if (enable) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = (32'(last_grant) + k) % NUM_REQ;
        if (!found && req[cand[IW-1:0]]) begin
          found                 = 1'b1;
          grant[cand[IW-1:0]]   = 1'b1;
          grant_idx             = cand[IW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ahb_rr_master.sv
// AHB-Lite master sharing one slave port among NUM_REQ requesters; one single transfer in flight.
module ahb_rr_master
  import ahb_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  hsel,
  output logic                  hwrite,
  output logic [1:0]            htrans,
  output logic [AW-1:0]         haddr,
  output logic [3:0]            hprot,
  output logic [DW-1:0]         hwdata,
  input  logic [DW-1:0]         hrdata,
  input  logic                  hready,
  input  logic [1:0]            hresp
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LastIdx = IW'(NUM_REQ - 1);

  state_e state_q, state_d;

  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [IW-1:0]      win_q, win_d;
  logic               write_q, write_d;
  logic [DW-1:0]      wdata_q, wdata_d;

  logic               hsel_q, hsel_d;
  logic               hwrite_q, hwrite_d;
  logic [1:0]         htrans_q, htrans_d;
  logic [AW-1:0]      haddr_q, haddr_d;
  logic [3:0]         hprot_q, hprot_d;
  logic [DW-1:0]      hwdata_q, hwdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               arb_en;

  // Gating with hrst keeps a requester from seeing an accept that the reset would discard.
  assign arb_en = (state_q == StIdle) && !hrst;

  ahb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arbiter (
    .req        (req_valid),
    .enable     (arb_en),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    hsel_d       = hsel_q;
    hwrite_d     = hwrite_q;
    htrans_d     = htrans_q;
    haddr_d      = haddr_q;
    hprot_d      = hprot_q;
    hwdata_d     = hwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          state_d      = StAddr;
          last_grant_d = grant_idx;
          win_d        = grant_idx;
          write_d      = req_write[grant_idx];
          wdata_d      = req_wdata[grant_idx*DW +: DW];
          hsel_d       = 1'b1;
          hwrite_d     = req_write[grant_idx];
          htrans_d     = HTRANS_NONSEQ;
          haddr_d      = req_addr[grant_idx*AW +: AW];
          hprot_d      = HPROT_DATA;
        end
      end
      StAddr: begin
        if (hready) begin
          state_d  = StData;
          hsel_d   = 1'b0;
          hwrite_d = 1'b0;
          htrans_d = HTRANS_IDLE;
          haddr_d  = '0;
          hprot_d  = '0;
          hwdata_d = write_q ? wdata_q : '0;
        end
      end
      StData: begin
        // A two-cycle ERROR response is just one wait state followed by this capture.
        if (hready) begin
          state_d            = StIdle;
          hwdata_d           = '0;
          rsp_valid_d[win_q] = 1'b1;
          rsp_rdata_d        = write_q ? '0 : hrdata;
          rsp_err_d          = (hresp == HRESP_ERROR);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q      <= StIdle;
      last_grant_q <= LastIdx;
      win_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      hsel_q       <= 1'b0;
      hwrite_q     <= 1'b0;
      htrans_q     <= HTRANS_IDLE;
      haddr_q      <= '0;
      hprot_q      <= '0;
      hwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      hsel_q       <= hsel_d;
      hwrite_q     <= hwrite_d;
      htrans_q     <= htrans_d;
      haddr_q      <= haddr_d;
      hprot_q      <= hprot_d;
      hwdata_q     <= hwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign hsel      = hsel_q;
  assign hwrite    = hwrite_q;
  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hprot     = hprot_q;
  assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_rr_master.sv
// Directed bench for ahb_rr_master with a response scoreboard and a scripted AHB slave.
module tb_ahb_rr_master;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            hclk = 1'b0;
  logic            hrst;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, hwdata, hrdata;
  logic            rsp_err, hsel, hwrite, hready;
  logic [1:0]      htrans, hresp;
  logic [AW-1:0]   haddr;
  logic [3:0]      hprot;

  ahb_rr_master #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .hclk      (hclk),
    .hrst      (hrst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .hsel      (hsel),
    .hwrite    (hwrite),
    .htrans    (htrans),
    .haddr     (haddr),
    .hprot     (hprot),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input int idx, input logic [31:0] rd, input logic e);
    exp_t x;
    x.idx   = idx;
    x.rdata = rd;
    x.err   = e;
    sb_q.push_back(x);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hsel"}, 64'(hsel), 64'd0);
    chk({tag, "_htrans"}, 64'(htrans), 64'd0);
    chk({tag, "_haddr"}, 64'(haddr), 64'd0);
    chk({tag, "_hwrite"}, 64'(hwrite), 64'd0);
    chk({tag, "_hprot"}, 64'(hprot), 64'd0);
    chk({tag, "_hwdata"}, 64'(hwdata), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
  endtask

  task automatic chk_addr_phase(input string tag, input logic [31:0] a, input logic w);
    chk({tag, "_hsel"}, 64'(hsel), 64'd1);
    chk({tag, "_htrans"}, 64'(htrans), 64'(2'b10));
    chk({tag, "_haddr"}, 64'(haddr), 64'(a));
    chk({tag, "_hwrite"}, 64'(hwrite), 64'(w));
    chk({tag, "_hprot"}, 64'(hprot), 64'(4'b0011));
  endtask

  // Scoreboard: every completion pulse is matched against the oldest expectation.
  always @(negedge hclk) begin : monitor
    exp_t e;
    if (rsp_valid !== '0) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_rsp_idx", 64'(rsp_valid), 64'd1 << e.idx);
        chk("sb_rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("sb_rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  initial begin
    hrst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    hrdata = '0; hready = 1'b1; hresp = 2'b00;
    tick(); tick();
    chk_all_zero("reset");
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    hrst = 1'b0;

    // Single write, zero wait
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0 +: 32] = 32'h1000_0010; req_wdata[0 +: 32] = 32'hDEAD_BEEF;
    #1 chk("t1_req_ready", 64'(req_ready), 64'd1);
    push(0, 32'h0, 1'b0);
    tick(); chk_addr_phase("t1_addr", 32'h1000_0010, 1'b1);
    req_valid = '0;
    tick();
    chk("t1_data_hwdata", 64'(hwdata), 64'hDEAD_BEEF);
    chk("t1_data_hsel", 64'(hsel), 64'd0);
    chk("t1_data_htrans", 64'(htrans), 64'd0);
    tick();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_err", 64'(rsp_err), 64'd0);

    // Read with 2 data-phase wait states
    req_valid = 2'b10; req_write = 2'b00; req_addr[32 +: 32] = 32'h0000_0020;
    #1 chk("t2_req_ready", 64'(req_ready), 64'd2);
    push(1, 32'h1234_5678, 1'b0);
    tick(); chk_addr_phase("t2_addr", 32'h20, 1'b0);
    req_valid = '0;
    tick(); hready = 1'b0;
    chk("t2_data_hwdata", 64'(hwdata), 64'd0);
    tick();
    chk("t2_wait1_rsp", 64'(rsp_valid), 64'd0);
    chk("t2_wait1_haddr", 64'(haddr), 64'd0);
    tick(); hready = 1'b1; hrdata = 32'h1234_5678;
    chk("t2_wait2_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd2);
    chk("t2_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);

    // Both requesters continuously valid after reset
    hrst = 1'b1; tick(); hrst = 1'b0;
    req_valid = 2'b11; req_write = 2'b11;
    req_addr[0 +: 32] = 32'h100; req_addr[32 +: 32] = 32'h200;
    req_wdata[0 +: 32] = 32'hA0A0_A0A0; req_wdata[32 +: 32] = 32'hB1B1_B1B1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      push(k % 2, 32'h0, 1'b0);
      tick();
      chk("t3_haddr", 64'(haddr), (k % 2 == 0) ? 64'h100 : 64'h200);
      if (k == 3) req_valid = '0;
      tick(); tick();
      chk("t3_rsp_period", 64'(rsp_valid), (k % 2 == 0) ? 64'd1 : 64'd2);
    end

    // ERROR response, then a normal transfer
    req_valid = 2'b01; req_write = 2'b00; req_addr[0 +: 32] = 32'h30;
    #1 chk("t4_req_ready", 64'(req_ready), 64'd1);
    push(0, 32'hBAD0_BAD0, 1'b1);
    tick(); req_valid = '0;
    tick(); hready = 1'b0; hresp = 2'b01;
    tick(); hready = 1'b1; hrdata = 32'hBAD0_BAD0;
    chk("t4_err_wait_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t4_rsp_err", 64'(rsp_err), 64'd1);
    hresp = 2'b00;
    req_valid = 2'b10; req_write = 2'b10;
    req_addr[32 +: 32] = 32'h40; req_wdata[32 +: 32] = 32'h0000_55AA;
    #1 chk("t4_next_ready", 64'(req_ready), 64'd2);
    push(1, 32'h0, 1'b0);
    tick(); req_valid = '0;
    tick(); chk("t4_next_hwdata", 64'(hwdata), 64'h55AA);
    tick();
    chk("t4_next_rsp", 64'(rsp_valid), 64'd2);
    chk("t4_next_err", 64'(rsp_err), 64'd0);

    // Address-phase stall of 3 cycles
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0 +: 32] = 32'h50; req_wdata[0 +: 32] = 32'hCAFE_F00D;
    #1 chk("t5_req_ready", 64'(req_ready), 64'd1);
    push(0, 32'h0, 1'b0);
    tick(); chk_addr_phase("t5_addr", 32'h50, 1'b1);
    req_valid = '0; hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_addr_phase("t5_stall", 32'h50, 1'b1);
      chk("t5_stall_rsp", 64'(rsp_valid), 64'd0);
      if (i == 2) hready = 1'b1;
    end
    tick();
    chk("t5_hwdata", 64'(hwdata), 64'hCAFE_F00D);
    chk("t5_data_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd1);

    // Reset during the data phase abandons the transfer
    req_valid = 2'b10; req_write = 2'b00; req_addr[32 +: 32] = 32'h60;
    #1 chk("t6_req_ready", 64'(req_ready), 64'd2);
    tick(); req_valid = '0;
    tick(); hready = 1'b0; hrst = 1'b1;
    tick();
    chk_all_zero("t6_reset");
    hrst = 1'b0; hready = 1'b1;
    tick();
    chk("t6_post_rsp", 64'(rsp_valid), 64'd0);
    req_valid = 2'b11; req_write = 2'b00;
    req_addr[0 +: 32] = 32'h70; req_addr[32 +: 32] = 32'h74; hrdata = 32'h0F0F_0F0F;
    #1 chk("t6_first_grant", 64'(req_ready), 64'd1);
    push(0, 32'h0F0F_0F0F, 1'b0);
    tick(); chk("t6_haddr", 64'(haddr), 64'h70);
    req_valid = '0;
    tick(); tick();
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd1);

    tick(); tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_rr_master.md
# ahb_rr_master

Round-robin AHB-Lite master that shares one AHB slave port among `NUM_REQ` local requesters.
- Each requester issues single read/write commands over a valid/ready handshake.
- The block arbitrates between them and sequences each command as an AHB NONSEQ single transfer: address phase, then data phase, with hready wait states.
- It returns read data and error status to the winning requester.
- It sits between the register/DMA clients and the AHB interconnect; the bench drives it the same way the AHB agent drives a slave.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `hclk`  in  1  clock. One clock.
- `hrst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester command valid.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*AW  packed addresses; requester i owns slice [i*AW +: AW].
- `req_wdata`  in  NUM_REQ*DW  packed write data.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `rsp_valid`  out  NUM_REQ  one-hot completion pulse.
- `rsp_rdata`  out  DW  read data, valid while rsp_valid is high.
- `rsp_err`  out  1  slave returned ERROR, valid while rsp_valid is high.
- `hsel`, `hwrite`  out  1  AHB select and direction.
- `htrans`  out  2  IDLE=2'b00, NONSEQ=2'b10.
- `haddr`  out  AW  AHB address.
- `hprot`  out  4  fixed 4'b0011 during address phase, otherwise 0.
- `hwdata`  out  DW  AHB write data.
- `hrdata`  in  DW  AHB read data.
- `hready`  in  1  transfer-done / wait-state input.
- `hresp`  in  2  OKAY=2'b00, ERROR=2'b01.

## Operation
- States are `IDLE`, `ADDR` and `DATA`. One transfer is outstanding at a time; there is no address/data overlap.
- **IDLE**
  - If any req_valid is high, the arbiter picks the winner by round-robin, searching from (last_grant+1) mod NUM_REQ.
  - req_ready[winner] is asserted combinationally in that cycle.
  - At the clock edge the block latches addr/write/wdata and the winner index, updates last_grant, and goes to ADDR.
- **ADDR**
  - Drives hsel=1, htrans=NONSEQ, haddr, hwrite, hprot=4'b0011.
  - Holds all of these while hready=0.
  - At an edge with hready=1, goes to DATA.
- **DATA**
  - Drives hsel=0, htrans=IDLE, hwrite=0, haddr=0.
  - hwdata carries the latched wdata on writes (0 on reads) and is held through wait states.
  - At an edge with hready=1:
    - rsp_rdata is captured from hrdata on reads, or set to 0 on writes.
    - rsp_err is set to (hresp==ERROR).
    - rsp_valid[winner] pulses for 1 cycle.
    - The state returns to IDLE.
- The two-cycle AHB ERROR response is handled naturally: the first cycle has hready=0 and is a wait; the capture happens in the second cycle.
- Requesters must hold valid and payload stable until req_ready. Withdrawing a request before req_ready is illegal.
- Reset:
  - All outputs are 0, the state is IDLE, and last_grant=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transfer abandons the transfer. No rsp_valid is issued for it.

## Timing
- Request seen at cycle 0: req_ready in cycle 0, address phase in cycle 1, data phase in cycle 2 (zero wait), rsp_valid in cycle 3.
- Each hready=0 cycle adds 1 cycle, in either phase.
- A new grant may occur in the same cycle as rsp_valid, so back-to-back throughput is 1 transfer per 3 cycles.
- All AHB and rsp outputs are registered. Only req_ready is combinational, from state, req_valid and last_grant.
- With a single requester asserting continuously, the same index is granted each time.

## Structure
- Package `ahb_ctrl_pkg`:
  - htrans and hresp encodings.
  - HPROT_DATA = 4'b0011.
  - State enum {IDLE, ADDR, DATA}.
- Sub-module `ahb_rr_arbiter`, parameterised by NUM_REQ:
  - Inputs: req vector, enable, last_grant.
  - Outputs: one-hot grant and encoded index.
- The top level holds the FSM and the latches.

## Test plan
- **Single write, zero wait.** Req0 writes addr 0x1000_0010, data 0xDEAD_BEEF; the slave returns hready=1 throughout.
  - NONSEQ/haddr appear in cycle 1 and hwdata=0xDEADBEEF in cycle 2.
  - rsp_valid[0] pulses in cycle 3 with rsp_err=0.
- **Read with 2 wait states in the data phase.** Req1 reads 0x20; hrdata=0x1234_5678.
  - rsp_rdata=0x12345678 arrives 2 cycles later than the zero-wait case.
  - haddr is held stable.
- **Both requesters valid continuously after reset.** Grants alternate 0,1,0,1.
  - Each completes with the correct index in rsp_valid.
  - The period is 3 cycles.
- **ERROR response.** The slave returns hresp=ERROR with hready=0, then ERROR with hready=1.
  - rsp_err=1 with rsp_valid.
  - The next transfer proceeds normally.
- **Address-phase stall.** hready=0 for 3 cycles in ADDR.
  - hsel, htrans, haddr and hwrite are held.
  - No rsp_valid appears before the data phase completes.
- **hrst asserted during DATA.** In the next cycle all outputs are 0, with no rsp_valid.
  - After reset, requester 0 wins first.
